li_expander: RTL and testbench

LI_EXPANDER -- requirements
Module: li_expander

---
 rtl/li_expander_pkg.sv | 15 +
 rtl/li_expander.sv | 116 +++++++++++
 tb/tb_li_expander.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/li_expander_pkg.sv
// Shared MIPS definitions for the load-immediate expander.
// Holds the I-type opcodes used to rebuild a 32-bit constant and the
// state encoding of the expander FSM.
package li_expander_pkg;

    localparam logic [5:0] OP_LUI = 6'b001111;
    localparam logic [5:0] OP_ORI = 6'b001101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EMIT_LUI = 2'd1,
        ST_EMIT_ORI = 2'd2
    } li_state_t;

endpackage

// File: rtl/li_expander.sv
// Load-immediate expander.
// Accepts a 32-bit constant and a destination register, then emits the
// MIPS LUI/ORI sequence that rebuilds the constant in that register.
// With SKIP_ZERO=1 a LUI whose upper half is zero, or an ORI whose lower
// half is zero after a LUI, is left out; a zero constant still yields a
// single ORI rt,$zero,0.
//
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   req_valid    request present
//   req_ready    block is idle and accepts a request
//   req_value    constant to materialise
//   req_rt       destination register number
//   instr_valid  instr carries a valid instruction word
//   instr_ready  consumer accepts instr
//   instr        emitted instruction word
//   instr_last   final word of the current sequence
//   busy         FSM is not idle
module li_expander
    import li_expander_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_value,
    input  logic [4:0]  req_rt,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic        instr_last,
    output logic        busy
);

    li_state_t   state;
    li_state_t   state_nxt;
    logic [31:0] value_q;
    logic [4:0]  rt_q;
    logic        accept;
    logic        hi_nz;
    logic        lo_nz;
    logic        lui_in_seq;

    assign accept = req_valid && (state == ST_IDLE);
    assign hi_nz  = (value_q[31:16] != 16'd0);
    assign lo_nz  = (value_q[15:0] != 16'd0);

    // Whether this sequence contains a LUI follows from the captured value
    // alone, so the ORI rs field needs no extra flag.
    assign lui_in_seq = hi_nz || !SKIP_ZERO;

    // State register and request capture; the request inputs are only
    // sampled on acceptance so later changes cannot disturb a sequence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            value_q <= 32'd0;
            rt_q    <= 5'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                value_q <= req_value;
                rt_q    <= req_rt;
            end
        end
    end

    // Next-state and output decode. Outputs depend on the state and the
    // captured registers only, never on instr_ready.
    always_comb begin
        state_nxt   = state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        instr_valid = 1'b0;
        instr       = 32'd0;
        instr_last  = 1'b0;

        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    // Decide from the incoming value, the registers are not
                    // loaded yet.
                    if ((req_value[31:16] != 16'd0) || !SKIP_ZERO) begin
                        state_nxt = ST_EMIT_LUI;
                    end else begin
                        state_nxt = ST_EMIT_ORI;
                    end
                end
            end
            ST_EMIT_LUI: begin
                instr_valid = 1'b1;
                instr       = {OP_LUI, 5'd0, rt_q, value_q[31:16]};
                instr_last  = !lo_nz && SKIP_ZERO;
                if (instr_ready) begin
                    state_nxt = (lo_nz || !SKIP_ZERO) ? ST_EMIT_ORI : ST_IDLE;
                end
            end
            ST_EMIT_ORI: begin
                instr_valid = 1'b1;
                instr       = {OP_ORI, (lui_in_seq ? rt_q : 5'd0), rt_q, value_q[15:0]};
                instr_last  = 1'b1;
                if (instr_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_li_expander.sv
// Self-checking bench for li_expander.
// Two instances: dut_skip (SKIP_ZERO=1) and dut_full (SKIP_ZERO=0).
// Expected words are queued when a request is driven and compared when the
// DUT hands a word over.
module tb_li_expander;

    typedef struct packed {
        logic [31:0] word;
        logic        last;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic [31:0] req_value   [2];
    logic [4:0]  req_rt      [2];
    logic        instr_valid [2];
    logic [31:0] instr       [2];
    logic        instr_last  [2];
    logic        busy        [2];
    logic        instr_ready;
    logic        ready_force;
    logic        rand_mode;
    logic        rand_bit;

    int checks;
    int errors;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    logic        prev_hold  [2];
    logic [31:0] prev_instr [2];
    logic        prev_last  [2];

    time last_accept_time;

    li_expander #(.SKIP_ZERO(1'b1)) dut_skip (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid[0]),
        .req_ready   (req_ready[0]),
        .req_value   (req_value[0]),
        .req_rt      (req_rt[0]),
        .instr_valid (instr_valid[0]),
        .instr_ready (instr_ready),
        .instr       (instr[0]),
        .instr_last  (instr_last[0]),
        .busy        (busy[0])
    );

    li_expander #(.SKIP_ZERO(1'b0)) dut_full (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid[1]),
        .req_ready   (req_ready[1]),
        .req_value   (req_value[1]),
        .req_rt      (req_rt[1]),
        .instr_valid (instr_valid[1]),
        .instr_ready (instr_ready),
        .instr       (instr[1]),
        .instr_last  (instr_last[1]),
        .busy        (busy[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Consumer readiness: either forced by the stimulus or random per cycle.
    assign instr_ready = rand_mode ? rand_bit : ready_force;

    always @(posedge clk) begin
        #1;
        rand_bit = 1'($urandom);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic int qSize(input int s);
        return (s == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void pushExp(input int s, input exp_t e);
        if (s == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    function automatic exp_t popExp(input int s);
        if (s == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    // Reference model of the LUI/ORI sequence.
    task automatic modelWords(input int s, input logic [31:0] value, input logic [4:0] rt,
                              output int n, output logic [31:0] w0, output logic [31:0] w1);
        logic        skip;
        logic        emit_lui;
        logic        emit_ori;
        logic [31:0] lui_w;
        logic [31:0] ori_w;
        skip     = (s == 0);
        emit_lui = !skip || (value[31:16] != 16'd0);
        emit_ori = !skip || (value[15:0] != 16'd0) || (value[31:16] == 16'd0);
        lui_w    = {6'b001111, 5'd0, rt, value[31:16]};
        ori_w    = {6'b001101, (emit_lui ? rt : 5'd0), rt, value[15:0]};
        n  = 0;
        w0 = 32'd0;
        w1 = 32'd0;
        if (emit_lui) begin
            w0 = lui_w;
            n  = 1;
        end
        if (emit_ori) begin
            if (n == 0) w0 = ori_w;
            else        w1 = ori_w;
            n++;
        end
    endtask

    // Waits for the chosen DUT to be ready, presents one request for a
    // single edge, queues its expected words and scrambles the request
    // inputs afterwards.
    task automatic applyStimulus(input int s, input logic [31:0] value, input logic [4:0] rt,
                                 input int n, input logic [31:0] w0, input logic [31:0] w1);
        int wait_cnt;
        wait_cnt = 0;
        @(negedge clk);
        while (!req_ready[s] && wait_cnt < 60) begin
            @(negedge clk);
            wait_cnt++;
        end
        if (!req_ready[s]) begin
            checkOutput("req_ready_timeout", 32'(req_ready[s]), 32'd1);
            return;
        end
        pushExp(s, '{word: w0, last: (n == 1)});
        if (n == 2) pushExp(s, '{word: w1, last: 1'b1});
        req_valid[s] = 1'b1;
        req_value[s] = value;
        req_rt[s]    = rt;
        @(posedge clk);
        last_accept_time = $time;
        #1;
        req_valid[s] = 1'b0;
        req_value[s] = $urandom;
        req_rt[s]    = 5'($urandom);
        checkOutput("first_valid", 32'(instr_valid[s]), 32'd1);
    endtask

    task automatic modelApply(input int s, input logic [31:0] value, input logic [4:0] rt);
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        modelWords(s, value, rt, n, w0, w1);
        applyStimulus(s, value, rt, n, w0, w1);
    endtask

    task automatic waitIdle(input int s);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while ((qSize(s) != 0 || busy[s]) && cnt < 60) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("drain_queue", 32'(qSize(s)), 32'd0);
        checkOutput("drain_busy", 32'(busy[s]), 32'd0);
    endtask

    // Output monitor: compares each handed-over word with the queue and
    // checks that a stalled word does not change.
    always @(negedge clk) begin
        exp_t e;
        for (int s = 0; s < 2; s++) begin
            if (rst_n) begin
                if (instr_valid[s] && prev_hold[s]) begin
                    checkOutput("hold_instr", instr[s], prev_instr[s]);
                    checkOutput("hold_last", 32'(instr_last[s]), 32'(prev_last[s]));
                end
                if (instr_valid[s] && instr_ready) begin
                    if (qSize(s) == 0) begin
                        checkOutput("queue_underflow", 32'(qSize(s)), 32'd1);
                    end else begin
                        e = popExp(s);
                        checkOutput("instr_word", instr[s], e.word);
                        checkOutput("instr_last", 32'(instr_last[s]), 32'(e.last));
                    end
                end
                prev_hold[s]  = instr_valid[s] && !instr_ready;
                prev_instr[s] = instr[s];
                prev_last[s]  = instr_last[s];
            end else begin
                prev_hold[s] = 1'b0;
            end
        end
    end

    initial begin
        time first_accept;
        logic [31:0] v;

        checks      = 0;
        errors      = 0;
        rst_n       = 1'b0;
        ready_force = 1'b1;
        rand_mode   = 1'b0;
        rand_bit    = 1'b0;
        for (int s = 0; s < 2; s++) begin
            req_valid[s] = 1'b0;
            req_value[s] = 32'hFFFF_FFFF;
            req_rt[s]    = 5'd31;
            prev_hold[s] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_valid", 32'(instr_valid[0]), 32'd0);
        checkOutput("rst_instr", instr[0], 32'd0);
        checkOutput("rst_last", 32'(instr_last[0]), 32'd0);
        checkOutput("rst_busy", 32'(busy[0]), 32'd0);
        checkOutput("rst_busy_full", 32'(busy[1]), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rel_ready", 32'(req_ready[0]), 32'd1);
        checkOutput("rel_ready_full", 32'(req_ready[1]), 32'd1);

        // Directed vectors with known encodings
        applyStimulus(0, 32'h1234_5678, 5'd8, 2, 32'h3C08_1234, 32'h3508_5678);
        waitIdle(0);
        applyStimulus(0, 32'h0000_BEEF, 5'd2, 1, 32'h3402_BEEF, 32'd0);
        waitIdle(0);
        applyStimulus(0, 32'h0000_0000, 5'd9, 1, 32'h3409_0000, 32'd0);
        waitIdle(0);
        applyStimulus(0, 32'hABCD_0000, 5'd31, 1, 32'h3C1F_ABCD, 32'd0);
        waitIdle(0);
        applyStimulus(1, 32'hABCD_0000, 5'd31, 2, 32'h3C1F_ABCD, 32'h37FF_0000);
        waitIdle(1);
        applyStimulus(1, 32'h0000_0000, 5'd9, 2, 32'h3C09_0000, 32'h3529_0000);
        waitIdle(1);
        applyStimulus(0, 32'h1234_5678, 5'd0, 2, 32'h3C00_1234, 32'h3400_5678);
        waitIdle(0);

        // Back-to-back two-word requests: one accept every three cycles
        applyStimulus(0, 32'h1111_2222, 5'd3, 2, 32'h3C03_1111, 32'h3463_2222);
        first_accept = last_accept_time;
        applyStimulus(0, 32'h3333_4444, 5'd4, 2, 32'h3C04_3333, 32'h3484_4444);
        checkOutput("b2b_gap", 32'((last_accept_time - first_accept) / 10), 32'd3);
        waitIdle(0);

        // Back-pressure during the LUI
        ready_force = 1'b0;
        applyStimulus(0, 32'h1234_5678, 5'd8, 2, 32'h3C08_1234, 32'h3508_5678);
        repeat (3) begin
            @(negedge clk);
            checkOutput("bp_instr", instr[0], 32'h3C08_1234);
            checkOutput("bp_ready", 32'(req_ready[0]), 32'd0);
            checkOutput("bp_busy", 32'(busy[0]), 32'd1);
        end
        ready_force = 1'b1;
        waitIdle(0);

        // Reset after the LUI handshake aborts the ORI
        applyStimulus(0, 32'h1234_5678, 5'd8, 2, 32'h3C08_1234, 32'h3508_5678);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(instr_valid[0]), 32'd0);
        checkOutput("abort_busy", 32'(busy[0]), 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("post_abort_valid", 32'(instr_valid[0]), 32'd0);
            checkOutput("post_abort_ready", 32'(req_ready[0]), 32'd1);
        end

        // Random constants under random back-pressure on both instances
        rand_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = $urandom;
            case (i % 4)
                0: v[31:16] = 16'd0;
                1: v[15:0]  = 16'd0;
                2: if (i == 6) v = 32'd0;
                default: ;
            endcase
            modelApply(i % 2, v, 5'($urandom_range(0, 31)));
        end
        waitIdle(0);
        waitIdle(1);
        rand_mode = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
